// File: rtl/img_stream_arbiter.sv
// Round-robin, frame-locked arbiter merging NUM_PORTS valid/stall streams into one registered stream.
// Optional idle-lock release is enabled by defining IMG_ARB_TIMEOUT_EN.
module img_stream_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SW            = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            in_valid,
    input  logic [NUM_PORTS-1:0]            in_last,
    output logic [NUM_PORTS-1:0]            upstream_stall,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    output logic                            out_last,
    output logic [SW-1:0]                   out_src,
    input  logic                            downstream_stall,
    output logic                            busy,
    output logic                            timeout_pulse
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_LOCKED = 1'b1;
    localparam logic [SW-1:0] LAST_IDX  = SW'(NUM_PORTS - 1);

    if (NUM_PORTS < 2 || NUM_PORTS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("img_stream_arbiter: parameter out of range");
    end

    function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    logic [0:0]            state;
    logic [SW-1:0]         rr_ptr;
    logic [SW-1:0]         lock_idx;
    logic                  can_load_p0;
    logic                  arb_hit_p0;
    logic [SW-1:0]         arb_idx_p0;
    logic [SW-1:0]         cand_p0;
    logic                  grant_vld_p0;
    logic [SW-1:0]         grant_idx_p0;
    logic                  accept_p0;
    logic [DATA_WIDTH-1:0] sel_data_p0;
    logic                  sel_last_p0;
    logic                  force_release;

    // Stage p0: arbitration and acceptance, all combinational from current state.
    always_comb begin
        arb_hit_p0 = 1'b0;
        arb_idx_p0 = '0;
        cand_p0    = rr_ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!arb_hit_p0 && in_valid[cand_p0]) begin
                arb_hit_p0 = 1'b1;
                arb_idx_p0 = cand_p0;
            end
            cand_p0 = wrap_inc(cand_p0);
        end
    end

    assign can_load_p0  = !out_valid || !downstream_stall;
    assign grant_vld_p0 = (state == ST_LOCKED) ? 1'b1 : arb_hit_p0;
    assign grant_idx_p0 = (state == ST_LOCKED) ? lock_idx : arb_idx_p0;
    assign accept_p0    = grant_vld_p0 && in_valid[grant_idx_p0] && can_load_p0;
    assign sel_last_p0  = in_last[grant_idx_p0];
    assign busy         = (state == ST_LOCKED);

    always_comb begin
        sel_data_p0    = '0;
        upstream_stall = '1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_idx_p0 == SW'(i)) begin
                sel_data_p0 = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            upstream_stall[i] = !(grant_vld_p0 && grant_idx_p0 == SW'(i) && can_load_p0);
        end
    end

`ifdef IMG_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] idle_cnt;

    assign force_release = (state == ST_LOCKED) && !in_valid[lock_idx]
                           && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= force_release;
            if (state != ST_LOCKED || accept_p0 || force_release) begin
                idle_cnt <= '0;
            end else if (!in_valid[lock_idx]) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign force_release = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Stage p1: output register and frame-lock state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            lock_idx  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            if (can_load_p0) begin
                out_valid <= accept_p0;
                out_last  <= accept_p0 && sel_last_p0;
                if (accept_p0) begin
                    out_data <= sel_data_p0;
                    out_src  <= grant_idx_p0;
                end
            end
            if (accept_p0) begin
                if (sel_last_p0) begin
                    state  <= ST_IDLE;
                    rr_ptr <= wrap_inc(grant_idx_p0);
                end else begin
                    state    <= ST_LOCKED;
                    lock_idx <= grant_idx_p0;
                end
            end else if (force_release) begin
                state  <= ST_IDLE;
                rr_ptr <= wrap_inc(lock_idx);
            end
        end
    end

endmodule

// File: tb/tb_img_stream_arbiter.sv
// Directed self-checking bench for img_stream_arbiter (4 ports, 32-bit words, TIMEOUT_CYCLES=8).
module tb_img_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    upstream_stall;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;
    logic [1:0]      out_src;
    logic            downstream_stall;
    logic            busy;
    logic            timeout_pulse;

    int n_cmp  = 0;
    int n_fail = 0;

    img_stream_arbiter #(
        .NUM_PORTS(N),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_last(in_last),
        .upstream_stall(upstream_stall),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_last(out_last),
        .out_src(out_src),
        .downstream_stall(downstream_stall),
        .busy(busy),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic l, input logic [DW-1:0] d);
        in_valid[p]          = v;
        in_last[p]           = l;
        in_data[p*DW +: DW]  = d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                           input logic l, input logic [1:0] s);
        chk({tag, "_valid"}, out_valid, v);
        chk({tag, "_data"},  out_data,  d);
        chk({tag, "_last"},  out_last,  l);
        chk({tag, "_src"},   out_src,   s);
    endtask

    initial begin
        reset            = 1'b1;
        in_data          = '0;
        in_valid         = '0;
        in_last          = '0;
        downstream_stall = 1'b0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_last",  out_last, 0);
        chk("rst_src",   out_src, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_tmo",   timeout_pulse, 0);
        reset = 1'b0;

        // Port 0 three-word frame.
        drive(0, 1, 0, 32'hA0);
        #1 chk("f0_stall", upstream_stall, 4'b1110);
        tick();
        chk_out("f0_w0", 1, 32'hA0, 0, 0);
        chk("f0_busy0", busy, 1);
        drive(0, 1, 0, 32'hA1);
        tick();
        chk_out("f0_w1", 1, 32'hA1, 0, 0);
        chk("f0_busy1", busy, 1);
        drive(0, 1, 1, 32'hA2);
        tick();
        chk_out("f0_w2", 1, 32'hA2, 1, 0);
        chk("f0_busy2", busy, 0);
        drive(0, 0, 0, 32'h0);
        tick();
        chk("f0_idle", out_valid, 0);

        // Ports 1 and 3 collide; port 1 first, then port 3 with no bubble.
        drive(1, 1, 0, 32'h10);
        drive(3, 1, 0, 32'h30);
        #1 chk("col_stall0", upstream_stall, 4'b1101);
        tick();
        chk_out("col_p1w0", 1, 32'h10, 0, 1);
        drive(1, 1, 1, 32'h11);
        #1 chk("col_stall1", upstream_stall, 4'b1101);
        tick();
        chk_out("col_p1w1", 1, 32'h11, 1, 1);
        drive(1, 0, 0, 32'h0);
        #1 chk("col_stall2", upstream_stall, 4'b0111);
        tick();
        chk_out("col_p3w0", 1, 32'h30, 0, 3);
        drive(3, 1, 1, 32'h31);
        tick();
        chk_out("col_p3w1", 1, 32'h31, 1, 3);
        drive(3, 0, 0, 32'h0);
        tick();
        chk("col_idle", out_valid, 0);

        // Downstream stall held for 4 cycles mid-frame of port 2.
        drive(2, 1, 0, 32'h20);
        tick();
        chk_out("ds_w0", 1, 32'h20, 0, 2);
        drive(2, 1, 0, 32'h21);
        downstream_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1 chk("ds_stall_all", upstream_stall, 4'b1111);
            tick();
            chk_out("ds_hold", 1, 32'h20, 0, 2);
        end
        downstream_stall = 1'b0;
        #1 chk("ds_release", upstream_stall, 4'b1011);
        tick();
        chk_out("ds_w1", 1, 32'h21, 0, 2);
        drive(2, 1, 1, 32'h22);
        tick();
        chk_out("ds_w2", 1, 32'h22, 1, 2);
        drive(2, 0, 0, 32'h0);
        tick();
        chk("ds_idle", out_valid, 0);

        // Fairness from rr_ptr=0 with all ports offering single-word frames.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < N; p++) drive(p, 1, 1, 32'h40 + p);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out("rr", 1, 32'h40 + (k % 4), 1, 2'(k % 4));
        end
        for (int p = 0; p < N; p++) drive(p, 0, 0, 32'h0);
        tick();
        chk("rr_idle", out_valid, 0);

        // Reset mid-frame of port 2, then port 0 wins from rr_ptr=0.
        drive(2, 1, 0, 32'h50);
        tick();
        chk_out("mr_w0", 1, 32'h50, 0, 2);
        chk("mr_busy", busy, 1);
        drive(2, 1, 0, 32'h51);
        reset = 1'b1;
        tick();
        chk("mr_valid", out_valid, 0);
        chk("mr_busy0", busy, 0);
        reset = 1'b0;
        drive(0, 1, 1, 32'h60);
        #1 chk("mr_stall", upstream_stall, 4'b1110);
        tick();
        chk_out("mr_p0", 1, 32'h60, 1, 0);
        drive(0, 0, 0, 32'h0);
        drive(2, 0, 0, 32'h0);
        tick();
        chk("mr_idle", out_valid, 0);

`ifdef IMG_ARB_TIMEOUT_EN
        // Port 1 locks then goes silent; port 2 waits behind it.
        drive(1, 1, 0, 32'h70);
        tick();
        chk_out("to_w0", 1, 32'h70, 0, 1);
        drive(1, 0, 0, 32'h0);
        drive(2, 1, 1, 32'h80);
        for (int c = 1; c < 8; c++) begin
            tick();
            chk("to_wait_pulse", timeout_pulse, 0);
            chk("to_wait_busy", busy, 1);
            chk("to_wait_valid", out_valid, 0);
        end
        tick();
        chk("to_pulse", timeout_pulse, 1);
        chk("to_busy", busy, 0);
        chk("to_stall", upstream_stall, 4'b1011);
        tick();
        chk("to_pulse_end", timeout_pulse, 0);
        chk_out("to_p2", 1, 32'h80, 1, 2);
        drive(2, 0, 0, 32'h0);
        tick();
`else
        chk("no_tmo", timeout_pulse, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/img_stream_arbiter.md
Name: img_stream_arbiter

Overview:
- Round-robin, frame-locked arbiter that merges NUM_PORTS producer streams into the single 32-bit valid/stall stream feeding the image model.
- A grant is held from a frame's first word until its in_last word is accepted, so frames never interleave.
- The output is one registered stage with the same valid/stall semantics as the downstream consumer.
- Source index travels with every word so downstream logic can route results back.

Parameters:
- NUM_PORTS, 4, number of requesting streams (2..16).
- DATA_WIDTH, 32, word width.
- TIMEOUT_CYCLES, 256, idle-cycle limit for a locked grant; used only with the optional feature.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_data  in  NUM_PORTS*DATA_WIDTH  packed words; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  in  NUM_PORTS  per-port word valid
- in_last  in  NUM_PORTS  per-port end-of-frame marker, qualified by in_valid
- upstream_stall  out  NUM_PORTS  per-port stall; producer holds data/valid/last while high
- out_data  out  DATA_WIDTH  registered output word
- out_valid  out  1  registered output valid
- out_last  out  1  registered end-of-frame
- out_src  out  SW  source port of out_data, where SW = max(1, clog2(NUM_PORTS))
- downstream_stall  in  1  consumer stall
- busy  out  1  high while a grant is locked (state LOCKED)
- timeout_pulse  out  1  one-cycle pulse on forced release; tied 0 without the optional feature

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, out_src=0, busy=0, timeout_pulse=0, rr_ptr=0, state=IDLE.
- Reset mid-frame drops the lock and discards any word held in the output register.
- can_load = !out_valid || !downstream_stall.
  - When can_load is true, the output register loads the granted port's data/valid/last/src (or loads out_valid=0 if nothing is accepted).
  - Otherwise the output register holds.
- Word accepted from port i in a cycle when grant==i && in_valid[i] && can_load.
  - upstream_stall[i] = !(grant==i && can_load), combinational.
  - Non-granted ports always see stall=1.
- Latency: 1 cycle from acceptance to out_valid. Full throughput of 1 word/cycle within a frame.
- Arbitration: search starts at rr_ptr and wraps modulo NUM_PORTS; the first port with in_valid high wins.
- State IDLE:
  - Grant is combinational from the arbitration; the first word is accepted the same cycle if can_load (no bubble).
  - Accepted word with in_last=1 (single-word frame): stay IDLE, rr_ptr = (winner+1) mod NUM_PORTS.
  - Accepted word with in_last=0: go to LOCKED, latch grant=winner.
  - No acceptance (no requester, or !can_load): stay IDLE, rr_ptr unchanged.
- State LOCKED:
  - Grant fixed to the latched port. Other ports' requests are ignored.
  - Gaps (in_valid low) are permitted: out_valid deasserts and the lock is kept.
  - Accepted word with in_last=1: return to IDLE, rr_ptr = (grant+1) mod NUM_PORTS. A new frame can be granted the very next cycle.
- Simultaneous requests: the nearest port at or after rr_ptr wins. The order is strictly fair; no port waits more than NUM_PORTS-1 frames.
- in_last is ignored when in_valid=0.
- Data on non-granted ports is never sampled.

Optional Feature:
- Macro: IMG_ARB_TIMEOUT_EN.
- With the macro: in LOCKED, a counter increments each cycle the granted port has in_valid=0 and clears on any acceptance.
  - When the counter reaches TIMEOUT_CYCLES, force return to IDLE, set rr_ptr=(grant+1) mod NUM_PORTS, and pulse timeout_pulse for 1 cycle.
  - No synthetic last word is emitted.
  - The counter resets to 0 on reset and on entry to LOCKED.
- Without the macro: no counter logic; a lock is held indefinitely until last; timeout_pulse is constant 0.

Test Plan:
- Reset, then port0 sends 3-word frame 0xA0,0xA1,0xA2 (last on 0xA2), no stall -> out shows those words on 3 consecutive cycles, starting 1 cycle after first accept; out_src=0; out_last only with 0xA2; busy high for 2 cycles.
- Ports 1 and 3 both send a 2-word frame starting the same cycle, rr_ptr=0 -> port1 frame (0x10,0x11) fully out first, then port3 (0x30,0x31) with no bubble; upstream_stall[3]=1 throughout port1's frame.
- downstream_stall held high for 4 cycles with out_valid=1 mid-frame -> out_data constant; upstream_stall[grant]=1; no word lost or duplicated after release.
- Fairness: all 4 ports continuously offer single-word frames for 8 accepts -> out_src sequence 0,1,2,3,0,1,2,3.
- Reset asserted mid-frame of port2 -> next cycle out_valid=0 and busy=0; the following grant goes to port0 if it is requesting (rr_ptr=0).
- With IMG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: port1 sends one non-last word, then idles -> timeout_pulse high exactly once, 8 cycles after the accept; busy drops; port2's pending frame is granted next.
